tf_addr_sched: RTL
==================

Name: tf_addr_sched

Overview:
- Sequences twiddle-factor ROM reads for an in-place radix-4 DIF FFT of N = 4^LOG4N points, one radix-4 butterfly per cycle.
- Generates the four 8-bit twiddle exponents (EXP0..EXP3) for each butterfly, stage by stage.
- Tracks the ROM's 1-cycle read latency and flags when TF0..TF3 are valid for the butterfly datapath.
- Sits between the FFT top-level control (START/DONE) and the 4-port twiddle ROM bank (256 x 64-bit table of W_256^k).

Parameters:
- LOG4N, 4, number of radix-4 stages; N = 4^LOG4N; legal range 1..4.
- EXP_W, 8, exponent/ROM address width; fixed at 8 (256-entry table).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  one-cycle request to begin a transform; honoured only in IDLE.
- READY  in  1  downstream accepts the current butterfly this cycle.
- EXP0  out  8  twiddle exponent for butterfly output leg 0 (ROM address).
- EXP1  out  8  twiddle exponent for leg 1.
- EXP2  out  8  twiddle exponent for leg 2.
- EXP3  out  8  twiddle exponent for leg 3.
- EXP_VALID  out  1  EXP0..3 describe a live butterfly.
- STAGE  out  2  current stage index s.
- BFLY  out  6  butterfly index b within the stage; only bits [2*LOG4N-3:0] are meaningful.
- TF_VALID  out  1  ROM outputs TF0..3 correspond to a butterfly issued the previous cycle.
- TF_LAST  out  1  qualifies TF_VALID: final butterfly of final stage.
- BUSY  out  1  high from the cycle after START is accepted until the cycle after DONE.
- DONE  out  1  one-cycle pulse coincident with the final TF_VALID.

Behaviour:
- All outputs are registered. Reset values: all zero. FSM state = IDLE.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE: START=1 -> RUN, with s=0, b=0, BUSY=1, EXP_VALID=1 next cycle.
  - RUN: on issue (EXP_VALID & READY), b increments. When b = N/4-1, b wraps to 0 and s increments.
  - Issue of s = LOG4N-1, b = N/4-1 -> FLUSH, with EXP_VALID=0.
  - FLUSH: lasts exactly one cycle; TF_VALID=1, TF_LAST=1, DONE=1; then -> IDLE. BUSY drops in the IDLE cycle.
- START outside IDLE is ignored. START coincident with RST is ignored.
- Exponent rule (per stage s, butterfly b):
  - Q = N/4^(s+1); j = b mod Q.
  - EXPm = ((m * j) << (2s + 8 - 2*LOG4N)) mod 256, for m = 0..3.
  - EXP0 is always 0. Intermediates are 10 bits wide; the result is truncated to 8 bits.
  - The final stage always yields all-zero exponents.
- Stall (READY=0 while EXP_VALID=1): EXP0..3, STAGE, BFLY are held unchanged, so the ROM keeps re-reading the same address and its output is stable.
- TF_VALID = registered (EXP_VALID & READY); 1-cycle latency matches the ROM.
- Throughput with READY held high: one butterfly per cycle. A transform takes LOG4N * N/4 issue cycles plus the FLUSH cycle.
- Sequence with READY=1 from START at edge k:
  - EXP_VALID high for cycles k+1 .. k+LOG4N*N/4.
  - TF_VALID one cycle behind EXP_VALID.
  - DONE at cycle k+LOG4N*N/4+1.
- RST mid-transform: next cycle all outputs are zero and state is IDLE. A final TF_VALID that was in flight is discarded.

Optional Feature:
- Macro TF_ADDR_SCHED_INV_EN.
- Defined: adds input port INV (1 bit), sampled only when START is accepted and held for the whole transform.
  - With INV=1, every exponent is replaced by (256 - EXPm) mod 256, i.e. conjugate twiddles for an IFFT. A zero exponent stays 0.
- Undefined: no INV port; forward exponents only.

Test Plan:
- Reset then idle: RST=1 two cycles, START=0 -> all outputs 0, BUSY=0 indefinitely.
- Full run, LOG4N=4, READY=1, START at edge k:
  - Stage 0, b=5 -> EXP = 0,5,10,15.
  - Stage 1, b=21 -> EXP = 0,20,40,60.
  - Stage 2, b=7 -> EXP = 0,48,96,144.
  - Stage 3 -> all exponents 0.
  - 256 TF_VALID pulses total; DONE and TF_LAST at k+257; BUSY=0 at k+258.
- Stall: READY=0 for 3 cycles at stage 0, b=10 -> EXP = 0,10,20,30 held; no TF_VALID during the stall. After release, b=11 follows with no skipped or duplicated BFLY.
- Small N, LOG4N=2: stage 0, b=3 -> shift 4 -> EXP = 0,48,96,144. DONE after 8 issues.
- START while BUSY, plus RST at stage 1, b=30: the extra START has no effect. RST -> IDLE next cycle, no DONE. A fresh START restarts at s=0, b=0.
- Inverse mode (TF_ADDR_SCHED_INV_EN defined, INV=1): stage 0, b=5 -> EXP = 0,251,246,241. Toggling INV mid-run has no effect.

Source files
------------

// File: rtl/tf_addr_sched.sv
// Twiddle-factor ROM address scheduler for an in-place radix-4 DIF FFT of N = 4^LOG4N points.
// Optional conjugate (IFFT) exponents are built in when TF_ADDR_SCHED_INV_EN is defined.
module tf_addr_sched #(
    parameter int LOG4N = 4,
    parameter int EXP_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             READY,
`ifdef TF_ADDR_SCHED_INV_EN
    input  logic             INV,
`endif
    output logic [EXP_W-1:0] EXP0,
    output logic [EXP_W-1:0] EXP1,
    output logic [EXP_W-1:0] EXP2,
    output logic [EXP_W-1:0] EXP3,
    output logic             EXP_VALID,
    output logic [1:0]       STAGE,
    output logic [5:0]       BFLY,
    output logic             TF_VALID,
    output logic             TF_LAST,
    output logic             BUSY,
    output logic             DONE
);

    // Handshake: a butterfly is issued on a rising edge where EXP_VALID and READY
    // are both high; while READY is low every address output holds its value.

    localparam int              NQ     = 1 << (2 * (LOG4N - 1));
    localparam logic [5:0]      B_LAST = 6'(NQ - 1);
    localparam logic [1:0]      S_LAST = 2'(LOG4N - 1);
    localparam logic [EXP_W-1:0] ZERO_E = '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       stage_q, stage_d;
    logic [5:0]       bfly_q, bfly_d;
    logic [EXP_W-1:0] exp0_q, exp0_d;
    logic [EXP_W-1:0] exp1_q, exp1_d;
    logic [EXP_W-1:0] exp2_q, exp2_d;
    logic [EXP_W-1:0] exp3_q, exp3_d;
    logic             exp_valid_q, exp_valid_d;
    logic             tf_valid_q, tf_valid_d;
    logic             tf_last_q, tf_last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             inv_q, inv_d;
    logic             inv_in;
    logic             issue;

`ifdef TF_ADDR_SCHED_INV_EN
    assign inv_in = INV;
`else
    assign inv_in = 1'b0;
`endif

    // Exponent of leg m for butterfly b of stage s: ((m * (b mod Q)) << shift) mod 256.
    function automatic logic [EXP_W-1:0] exp_calc(
        input logic [1:0] s,
        input logic [5:0] b,
        input logic [1:0] m,
        input logic       inv
    );
        logic [3:0]       qsh;
        logic [3:0]       shamt;
        logic [5:0]       qmask;
        logic [5:0]       j;
        logic [EXP_W-1:0] e;
        qsh   = 4'(2 * (LOG4N - 1)) - {1'b0, s, 1'b0};
        qmask = 6'((7'd1 << qsh) - 7'd1);
        j     = b & qmask;
        shamt = {1'b0, s, 1'b0} + 4'(8 - 2 * LOG4N);
        e     = EXP_W'((16'(m) * 16'(j)) << shamt);
        if (inv) begin
            e = ZERO_E - e;
        end
        return e;
    endfunction

    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        bfly_d      = bfly_q;
        inv_d       = inv_q;
        exp_valid_d = 1'b0;
        tf_valid_d  = 1'b0;
        tf_last_d   = 1'b0;
        done_d      = 1'b0;
        issue       = exp_valid_q & READY;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d     = ST_RUN;
                    stage_d     = 2'd0;
                    bfly_d      = 6'd0;
                    inv_d       = inv_in;
                    exp_valid_d = 1'b1;
                end
            end
            ST_RUN: begin
                exp_valid_d = 1'b1;
                tf_valid_d  = issue;
                if (issue) begin
                    if (bfly_q == B_LAST) begin
                        bfly_d = 6'd0;
                        if (stage_q == S_LAST) begin
                            state_d     = ST_FLUSH;
                            stage_d     = 2'd0;
                            exp_valid_d = 1'b0;
                            tf_last_d   = 1'b1;
                            done_d      = 1'b1;
                        end else begin
                            stage_d = stage_q + 2'd1;
                        end
                    end else begin
                        bfly_d = bfly_q + 6'd1;
                    end
                end
            end
            ST_FLUSH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        exp0_d = exp_calc(stage_d, bfly_d, 2'd0, inv_d);
        exp1_d = exp_calc(stage_d, bfly_d, 2'd1, inv_d);
        exp2_d = exp_calc(stage_d, bfly_d, 2'd2, inv_d);
        exp3_d = exp_calc(stage_d, bfly_d, 2'd3, inv_d);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            stage_q     <= 2'd0;
            bfly_q      <= 6'd0;
            exp0_q      <= '0;
            exp1_q      <= '0;
            exp2_q      <= '0;
            exp3_q      <= '0;
            exp_valid_q <= 1'b0;
            tf_valid_q  <= 1'b0;
            tf_last_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            inv_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            bfly_q      <= bfly_d;
            exp0_q      <= exp0_d;
            exp1_q      <= exp1_d;
            exp2_q      <= exp2_d;
            exp3_q      <= exp3_d;
            exp_valid_q <= exp_valid_d;
            tf_valid_q  <= tf_valid_d;
            tf_last_q   <= tf_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            inv_q       <= inv_d;
        end
    end

    assign EXP0      = exp0_q;
    assign EXP1      = exp1_q;
    assign EXP2      = exp2_q;
    assign EXP3      = exp3_q;
    assign EXP_VALID = exp_valid_q;
    assign STAGE     = stage_q;
    assign BFLY      = bfly_q;
    assign TF_VALID  = tf_valid_q;
    assign TF_LAST   = tf_last_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;

endmodule
